// File: rtl/assert_fire_scheduler.sv
// Small generic FIFO: registered storage, head visible the cycle after a push.
// Latency: push to rd_vld 1 cycle; flush empties it on the next edge.
// Backpressure: wr_vld is refused while full unless a pop happens in the same cycle.
module afs_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         full,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  assign rd_vld = (count != '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign pop    = rd_vld & rd_rdy;
  assign push   = wr_vld & (~full | pop);
  assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// Checker-fire scheduler: mask load/settle FSM, round-robin fire queue (ASSERT_FIRE_TIMESTAMP_EN adds evt_ts).
// Latency: fire sampled -> pending next cycle -> granted/pushed -> evt_valid one cycle later.
// Backpressure: grants stall while the queue is full; re-fires on a still-pending bit set evt_overflow.
module assert_fire_scheduler #(
  parameter int NUM_CHK       = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_load,
  input  logic [NUM_CHK-1:0]         cfg_mask,
  output logic [NUM_CHK-1:0]         chk_enable,
  output logic                       cfg_invalid,
  input  logic [NUM_CHK-1:0]         fire_in,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [$clog2(NUM_CHK)-1:0] evt_id,
  output logic                       evt_overflow,
`ifdef ASSERT_FIRE_TIMESTAMP_EN
  output logic [15:0]                evt_ts,
`endif
  input  logic                       ovf_clr
);
  localparam int IDW = $clog2(NUM_CHK);

  typedef enum logic [1:0] {RUN, LOAD, SETTLE} state_t;

`ifdef ASSERT_FIRE_TIMESTAMP_EN
  typedef struct packed {
    logic [15:0]    ts;
    logic [IDW-1:0] id;
  } evt_t;
`else
  typedef struct packed {
    logic [IDW-1:0] id;
  } evt_t;
`endif

  state_t             state, state_d;
  logic [3:0]         settle_cnt, settle_cnt_d;
  logic [NUM_CHK-1:0] mask_q, mask_d;
  logic               in_load;
  logic               sample_en;

  logic [NUM_CHK-1:0] pending, pending_d;
  logic [NUM_CHK-1:0] fire_s;
  logic [NUM_CHK-1:0] grant_oh;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     grant_idx;
  logic               grant_vld;
  logic               grant_en;
  logic               ovf_set;
  logic               fifo_full;
  evt_t               wr_evt;
  evt_t               head;

`ifdef ASSERT_FIRE_TIMESTAMP_EN
  logic [15:0]        ts_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RUN;
      settle_cnt <= '0;
      mask_q     <= '0;
    end else begin
      state      <= state_d;
      settle_cnt <= settle_cnt_d;
      mask_q     <= mask_d;
    end
  end

  always_comb begin
    state_d      = state;
    settle_cnt_d = settle_cnt;
    mask_d       = cfg_load ? cfg_mask : mask_q;
    chk_enable   = mask_q;
    cfg_invalid  = 1'b1;
    in_load      = 1'b0;
    sample_en    = 1'b0;
    case (state)
      RUN: begin
        cfg_invalid = 1'b0;
        sample_en   = 1'b1;
      end
      LOAD: begin
        chk_enable   = '0;
        in_load      = 1'b1;
        state_d      = SETTLE;
        settle_cnt_d = 4'(SETTLE_CYCLES);
      end
      SETTLE: begin
        if (settle_cnt <= 4'd1) state_d = RUN;
        else                    settle_cnt_d = settle_cnt - 4'd1;
      end
      default: state_d = RUN;
    endcase
    // A new load wins from any state, restarting an in-flight settle.
    if (cfg_load) state_d = LOAD;
  end

  assign fire_s   = sample_en ? (fire_in & mask_q) : '0;
  assign grant_en = ~in_load & (~fifo_full | (evt_valid & evt_ready));

  always_comb begin
    int cand;
    cand      = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NUM_CHK; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_CHK;
      if (!grant_vld && grant_en && pending[cand]) begin
        grant_vld = 1'b1;
        grant_idx = IDW'(cand);
      end
    end
  end

  assign grant_oh  = grant_vld ? (NUM_CHK'(1) << grant_idx) : '0;
  assign ovf_set   = |(fire_s & pending & ~grant_oh);
  assign pending_d = in_load ? '0 : ((pending & ~grant_oh) | fire_s);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending      <= '0;
      rr_ptr       <= IDW'(NUM_CHK - 1);
      evt_overflow <= 1'b0;
    end else begin
      pending <= pending_d;
      if (grant_vld) rr_ptr <= grant_idx;
      if (ovf_clr)      evt_overflow <= 1'b0;
      else if (ovf_set) evt_overflow <= 1'b1;
    end
  end

`ifdef ASSERT_FIRE_TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (!rst) ts_q <= '0;
    else      ts_q <= ts_q + 16'd1;
  end

  assign wr_evt.ts = ts_q;
  assign evt_ts    = head.ts;
`endif

  assign wr_evt.id = grant_idx;
  assign evt_id    = head.id;

  afs_fifo #(
    .W     ($bits(evt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (in_load),
    .wr_vld (grant_vld),
    .wr_dat (wr_evt),
    .full   (fifo_full),
    .rd_vld (evt_valid),
    .rd_rdy (evt_ready),
    .rd_dat (head)
  );
endmodule

// File: tb/tb_assert_fire_scheduler.sv
// Directed bench for assert_fire_scheduler (NUM_CHK=8, FIFO_DEPTH=4, SETTLE_CYCLES=2).
// Inputs change 1 time unit after a rising edge; outputs are read at that same point.
module tb_assert_fire_scheduler;
  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_load;
  logic [7:0] cfg_mask;
  logic [7:0] chk_enable;
  logic       cfg_invalid;
  logic [7:0] fire_in;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_id;
  logic       evt_overflow;
  logic       ovf_clr;
`ifdef ASSERT_FIRE_TIMESTAMP_EN
  logic [15:0] evt_ts;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  assert_fire_scheduler #(
    .NUM_CHK       (8),
    .FIFO_DEPTH    (4),
    .SETTLE_CYCLES (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_load     (cfg_load),
    .cfg_mask     (cfg_mask),
    .chk_enable   (chk_enable),
    .cfg_invalid  (cfg_invalid),
    .fire_in      (fire_in),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_id       (evt_id),
    .evt_overflow (evt_overflow),
`ifdef ASSERT_FIRE_TIMESTAMP_EN
    .evt_ts       (evt_ts),
`endif
    .ovf_clr      (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset;
    rst = 1'b0; cfg_load = 1'b0; cfg_mask = '0; fire_in = '0;
    evt_ready = 1'b0; ovf_clr = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic load_cfg(input logic [7:0] mask);
    cfg_load = 1'b1; cfg_mask = mask;
    tick;
    cfg_load = 1'b0;
    tick;
    tick;
    tick;
  endtask

  task automatic test_reset;
    checks++; if (chk_enable !== 8'h00) begin errors++; $display("FAIL reset_chk_enable: got %h expected 00", chk_enable); end
    checks++; if (cfg_invalid !== 1'b0) begin errors++; $display("FAIL reset_cfg_invalid: got %b expected 0", cfg_invalid); end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_evt_valid: got %b expected 0", evt_valid); end
    checks++; if (evt_id !== 3'd0) begin errors++; $display("FAIL reset_evt_id: got %0d expected 0", evt_id); end
    checks++; if (evt_overflow !== 1'b0) begin errors++; $display("FAIL reset_evt_overflow: got %b expected 0", evt_overflow); end
  endtask

  task automatic test_cfg_load;
    logic [7:0] exp_en  [4] = '{8'h00, 8'h05, 8'h05, 8'h05};
    logic       exp_inv [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    cfg_load = 1'b1; cfg_mask = 8'h05;
    tick;
    cfg_load = 1'b0; cfg_mask = 8'h00;
    for (int i = 0; i < 4; i++) begin
      checks++; if (chk_enable !== exp_en[i]) begin errors++; $display("FAIL cfg_chk_enable[%0d]: got %h expected %h", i, chk_enable, exp_en[i]); end
      checks++; if (cfg_invalid !== exp_inv[i]) begin errors++; $display("FAIL cfg_invalid[%0d]: got %b expected %b", i, cfg_invalid, exp_inv[i]); end
      if (i < 3) tick;
    end
    // Only bits 0 and 2 are enabled, so only those two ids may appear.
    evt_ready = 1'b1; fire_in = 8'hFF;
    tick;
    fire_in = 8'h00;
    tick;
    checks++; if (evt_valid !== 1'b1 || evt_id !== 3'd0) begin errors++; $display("FAIL mask_first: got v=%b id=%0d expected v=1 id=0", evt_valid, evt_id); end
    tick;
    checks++; if (evt_valid !== 1'b1 || evt_id !== 3'd2) begin errors++; $display("FAIL mask_second: got v=%b id=%0d expected v=1 id=2", evt_valid, evt_id); end
    tick;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL mask_empty: got v=%b expected 0", evt_valid); end
    evt_ready = 1'b0;
  endtask

  task automatic test_fire_all;
    evt_ready = 1'b1; fire_in = 8'hFF;
    tick;
    fire_in = 8'h00;
    tick;
    for (int i = 0; i < 8; i++) begin
      checks++; if (evt_valid !== 1'b1 || evt_id !== 3'(i)) begin errors++; $display("FAIL fire_all_seq[%0d]: got v=%b id=%0d expected v=1 id=%0d", i, evt_valid, evt_id, i); end
      tick;
    end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL fire_all_empty: got v=%b expected 0", evt_valid); end
    checks++; if (evt_overflow !== 1'b0) begin errors++; $display("FAIL fire_all_ovf: got %b expected 0", evt_overflow); end
    evt_ready = 1'b0;
  endtask

  task automatic test_overflow;
    logic [2:0] exp_ids [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3};
    evt_ready = 1'b0; fire_in = 8'h07;
    tick;
    fire_in = 8'h00;
    tick; tick; tick;
    // Three entries queued; bit 3 takes the last slot, then its re-fires are lost.
    fire_in = 8'h08;
    for (int i = 0; i < 6; i++) tick;
    fire_in = 8'h00;
    checks++; if (evt_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", evt_overflow); end
    checks++; if (evt_valid !== 1'b1 || evt_id !== 3'd0) begin errors++; $display("FAIL ovf_head: got v=%b id=%0d expected v=1 id=0", evt_valid, evt_id); end
    fire_in = 8'h08; ovf_clr = 1'b1;
    tick;
    fire_in = 8'h00; ovf_clr = 1'b0;
    checks++; if (evt_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr_priority: got %b expected 0", evt_overflow); end
    tick;
    checks++; if (evt_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr_hold: got %b expected 0", evt_overflow); end
    evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (evt_valid !== 1'b1 || evt_id !== exp_ids[i]) begin errors++; $display("FAIL ovf_drain[%0d]: got v=%b id=%0d expected v=1 id=%0d", i, evt_valid, evt_id, exp_ids[i]); end
      tick;
    end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain_empty: got v=%b expected 0", evt_valid); end
    evt_ready = 1'b0;
  endtask

  task automatic test_settle;
    evt_ready = 1'b0;
    cfg_load = 1'b1; cfg_mask = 8'hFF;
    tick;
    cfg_load = 1'b0; fire_in = 8'h01;
    checks++; if (cfg_invalid !== 1'b1) begin errors++; $display("FAIL settle_load_inv: got %b expected 1", cfg_invalid); end
    tick;
    tick;
    cfg_load = 1'b1;
    tick;
    cfg_load = 1'b0;
    checks++; if (cfg_invalid !== 1'b1 || chk_enable !== 8'h00) begin errors++; $display("FAIL settle_restart: got inv=%b en=%h expected inv=1 en=00", cfg_invalid, chk_enable); end
    tick;
    checks++; if (cfg_invalid !== 1'b1) begin errors++; $display("FAIL settle_restart_s1: got %b expected 1", cfg_invalid); end
    tick;
    checks++; if (cfg_invalid !== 1'b1) begin errors++; $display("FAIL settle_restart_s2: got %b expected 1", cfg_invalid); end
    fire_in = 8'h00;
    tick;
    checks++; if (cfg_invalid !== 1'b0 || chk_enable !== 8'hFF) begin errors++; $display("FAIL settle_run: got inv=%b en=%h expected inv=0 en=ff", cfg_invalid, chk_enable); end
    tick;
    tick;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL settle_no_event: got v=%b expected 0", evt_valid); end
  endtask

  task automatic test_full_push_pop;
    logic [2:0] exp_ids [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3};
    evt_ready = 1'b0; fire_in = 8'h1F;
    tick;
    fire_in = 8'h00;
    tick; tick; tick; tick;
    // Pointer was left at 3, so the grants run 4,0,1,2 and bit 3 waits.
    checks++; if (evt_valid !== 1'b1 || evt_id !== 3'd4) begin errors++; $display("FAIL full_head: got v=%b id=%0d expected v=1 id=4", evt_valid, evt_id); end
    tick;
    checks++; if (evt_id !== 3'd4) begin errors++; $display("FAIL full_head_stable: got id=%0d expected 4", evt_id); end
    evt_ready = 1'b1;
    tick;
    evt_ready = 1'b0;
    checks++; if (evt_valid !== 1'b1 || evt_id !== 3'd0) begin errors++; $display("FAIL full_pushpop_head: got v=%b id=%0d expected v=1 id=0", evt_valid, evt_id); end
    fire_in = 8'h08;
    tick;
    fire_in = 8'h00;
    checks++; if (evt_overflow !== 1'b0) begin errors++; $display("FAIL full_pushpop_granted: got ovf=%b expected 0", evt_overflow); end
    evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (evt_valid !== 1'b1 || evt_id !== exp_ids[i]) begin errors++; $display("FAIL full_drain[%0d]: got v=%b id=%0d expected v=1 id=%0d", i, evt_valid, evt_id, exp_ids[i]); end
      tick;
    end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL full_drain_empty: got v=%b expected 0", evt_valid); end
    evt_ready = 1'b0;
  endtask

`ifdef ASSERT_FIRE_TIMESTAMP_EN
  task automatic test_timestamp;
    do_reset;
    load_cfg(8'hFF);
    while (cyc < 99) tick;
    fire_in = 8'h01;
    tick;
    fire_in = 8'h00;
    tick;
    checks++; if (evt_valid !== 1'b1 || evt_ts !== 16'h0064) begin errors++; $display("FAIL ts_100: got v=%b ts=%h expected v=1 ts=0064", evt_valid, evt_ts); end
    evt_ready = 1'b1;
    tick;
    evt_ready = 1'b0;
    while (cyc < 65534) tick;
    fire_in = 8'h01;
    tick;
    tick;
    fire_in = 8'h00;
    tick;
    checks++; if (evt_valid !== 1'b1 || evt_ts !== 16'hFFFF) begin errors++; $display("FAIL ts_pre_wrap: got v=%b ts=%h expected v=1 ts=ffff", evt_valid, evt_ts); end
    evt_ready = 1'b1;
    tick;
    evt_ready = 1'b0;
    checks++; if (evt_valid !== 1'b1 || evt_ts !== 16'h0000) begin errors++; $display("FAIL ts_wrap: got v=%b ts=%h expected v=1 ts=0000", evt_valid, evt_ts); end
  endtask
`endif

  initial begin
    do_reset;
    test_reset;
    test_cfg_load;
    do_reset;
    load_cfg(8'hFF);
    test_fire_all;
    test_overflow;
    test_settle;
    test_full_push_pop;
`ifdef ASSERT_FIRE_TIMESTAMP_EN
    test_timestamp;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
